// File: rtl/controller_poller.sv
// Serial game-pad poller: latches both pads, shifts 8 bits each, commits atomically.
// Player-2 capture is built only when CONTROLLER_POLLER_P2_EN is defined.
//
// state    | meaning
// IDLE     | waiting for start; pads quiet
// LATCH    | pad_latch high for 2*CLK_DIV cycles
// WAIT_LO  | pad_clk low for CLK_DIV cycles, samples bit k on last cycle
// PULSE_HI | pad_clk high for CLK_DIV cycles
// COMMIT   | shift registers copied to result registers, valid set
module controller_poller #(
  parameter int CLK_DIV = 64
) (
  input  logic       clk_12_5875,
  input  logic       rst,
  input  logic       start,
  input  logic       SELECT_controller,
  input  logic       reg_sel,
  input  logic       write_enable,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       pad_data1,
  input  logic       pad_data2,
  output logic       busy,
  output logic       valid
);

  typedef enum logic [2:0] {IDLE, LATCH, WAIT_LO, PULSE_HI, COMMIT} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  state_t     state, state_nxt;
  logic [7:0] div_cnt;
  logic [2:0] k;
  logic       div_tc;
  logic [7:0] shift1, res1, res2;

  assign div_tc = (div_cnt == 8'd0);

  always_ff @(posedge clk_12_5875) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pad_latch = 1'b0;
    pad_clk   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LATCH;
      end
      LATCH: begin
        pad_latch = 1'b1;
        // k[0] marks the second half of the double-length latch window
        if (div_tc && k[0]) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (div_tc) state_nxt = (k == 3'd7) ? COMMIT : PULSE_HI;
      end
      PULSE_HI: begin
        pad_clk = 1'b1;
        if (div_tc) state_nxt = WAIT_LO;
      end
      COMMIT: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      div_cnt <= 8'd0;
      k       <= 3'd0;
      shift1  <= 8'h00;
      res1    <= 8'h00;
      valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_cnt <= DIV_LOAD;
            k       <= 3'd0;
          end
        end
        LATCH: begin
          if (div_tc) begin
            div_cnt <= DIV_LOAD;
            k       <= k[0] ? 3'd0 : 3'd1;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        WAIT_LO: begin
          if (div_tc) begin
            shift1[k] <= ~pad_data1;
            if (k != 3'd7) begin
              k       <= k + 3'd1;
              div_cnt <= DIV_LOAD;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        PULSE_HI: begin
          if (div_tc) div_cnt <= DIV_LOAD;
          else        div_cnt <= div_cnt - 8'd1;
        end
        COMMIT: begin
          res1    <= shift1;
          valid   <= 1'b1;
          k       <= 3'd0;
          div_cnt <= 8'd0;
        end
        default: begin
          div_cnt <= 8'd0;
          k       <= 3'd0;
        end
      endcase
    end
  end

`ifdef CONTROLLER_POLLER_P2_EN
  logic [7:0] shift2;

  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      shift2 <= 8'h00;
      res2   <= 8'h00;
    end else begin
      if (state == WAIT_LO && div_tc) shift2[k] <= ~pad_data2;
      if (state == COMMIT)            res2      <= shift2;
    end
  end
`else
  logic unused_pad_data2;
  assign unused_pad_data2 = pad_data2;
  assign res2 = 8'h00;
`endif

  assign data_oe  = SELECT_controller & ~write_enable;
  assign data_out = data_oe ? (reg_sel ? res2 : res1) : 8'h00;

endmodule

// File: tb/tb_controller_poller.sv
// Randomized scoreboard bench for controller_poller; the reference model tracks
// each poll by its phase offset from the accepted start cycle.
module tb_controller_poller;

  localparam int D       = 4;
  localparam int NCYCLES = 8000;

  logic       clk_12_5875 = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       SELECT_controller = 1'b0;
  logic       reg_sel = 1'b0;
  logic       write_enable = 1'b0;
  logic [7:0] data_out;
  logic       data_oe;
  logic       pad_latch;
  logic       pad_clk;
  logic       pad_data1 = 1'b1;
  logic       pad_data2 = 1'b1;
  logic       busy;
  logic       valid;

  controller_poller #(.CLK_DIV(D)) dut (
    .clk_12_5875      (clk_12_5875),
    .rst              (rst),
    .start            (start),
    .SELECT_controller(SELECT_controller),
    .reg_sel          (reg_sel),
    .write_enable     (write_enable),
    .data_out         (data_out),
    .data_oe          (data_oe),
    .pad_latch        (pad_latch),
    .pad_clk          (pad_clk),
    .pad_data1        (pad_data1),
    .pad_data2        (pad_data2),
    .busy             (busy),
    .valid            (valid)
  );

  always #5 clk_12_5875 = ~clk_12_5875;

  logic [12:0] exp_q[$];
  int          cyc_q[$];
  int          errors = 0;
  int          checks = 0;

  // expected word: {pad_latch, pad_clk, busy, valid, data_oe, data_out}
  always @(negedge clk_12_5875) begin
    if (exp_q.size() > 0) begin
      logic [12:0] e, got;
      int          c;
      e   = exp_q.pop_front();
      c   = cyc_q.pop_front();
      got = {pad_latch, pad_clk, busy, valid, data_oe, data_out};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d: got latch/clk/busy/valid/oe/data=%b%b%b%b%b/%h required %b%b%b%b%b/%h",
                 c, got[12], got[11], got[10], got[9], got[8], got[7:0],
                 e[12], e[11], e[10], e[9], e[8], e[7:0]);
      end
    end
  end

  bit         active;
  int         s;
  logic [7:0] sh1, sh2, m1, m2;
  bit         mvalid;

  initial begin
    int phase;
    bit hold;
    bit e_latch, e_clk, e_busy, e_oe;
    logic [7:0] e_data;

    active = 0; s = 0; sh1 = 0; sh2 = 0; m1 = 0; m2 = 0; mvalid = 0; hold = 0;
    repeat (3) @(posedge clk_12_5875);

    for (int cyc = 0; cyc < NCYCLES; cyc++) begin
      #1;
      if ((cyc % 1000) == 500) hold = 1;
      if ((cyc % 1000) == 700) hold = 0;
      rst               = ($urandom_range(0, 499) == 0);
      start             = hold ? 1'b1 : ($urandom_range(0, 29) == 0);
      SELECT_controller = ($urandom_range(0, 3) != 0);
      write_enable      = ($urandom_range(0, 3) == 0);
      reg_sel           = 1'($urandom_range(0, 1));
      pad_data1         = 1'($urandom_range(0, 1));
      pad_data2         = 1'($urandom_range(0, 1));

      phase   = cyc - s;
      e_busy  = active;
      e_latch = active && phase >= 1 && phase <= 2 * D;
      e_clk   = active && phase > 3 * D && phase <= 17 * D &&
                (((phase - 3 * D - 1) / D) % 2 == 0);
      e_oe    = SELECT_controller && !write_enable;
      e_data  = e_oe ? (reg_sel ? m2 : m1) : 8'h00;
      exp_q.push_back({e_latch, e_clk, e_busy, mvalid, e_oe, e_data});
      cyc_q.push_back(cyc);

      if (rst) begin
        active = 0; sh1 = 0; sh2 = 0; m1 = 0; m2 = 0; mvalid = 0;
      end else if (active) begin
        if (phase >= 3 * D && phase <= 17 * D && ((phase - 3 * D) % (2 * D)) == 0) begin
          sh1[(phase - 3 * D) / (2 * D)] = ~pad_data1;
          sh2[(phase - 3 * D) / (2 * D)] = ~pad_data2;
        end
        if (phase == 17 * D + 1) begin
          m1 = sh1;
`ifdef CONTROLLER_POLLER_P2_EN
          m2 = sh2;
`else
          m2 = 8'h00;
`endif
          mvalid = 1;
          active = 0;
        end
      end else if (start) begin
        active = 1;
        s      = cyc;
      end

      @(posedge clk_12_5875);
    end

    @(negedge clk_12_5875);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
